scan_chain_ctrl: RTL and testbench
==================================

// Module: scan_chain_ctrl
// PURPOSE
//   Scan-test initiator for a chain of mux-scan flip-flops (D/TI/TE/CP cells).
//   Drives the chain's TE and TI, shifts a stimulus pattern in, and pulses one
//   functional capture cycle (TE=0). It then shifts the response out of SO and
//   compares it against an expected vector. Sits between the test
//   sequencer/ATE port and each scan chain in the TECH test wrapper.
// PARAMETERS
//   CHAIN_LEN  16  number of scan flops in the chain (N), >= 2
//   CNT_W      5   bit-count width; must satisfy 2**CNT_W > CHAIN_LEN
// PORTS
//   CP        in   1          rising-edge clock; also clocks the scan chain
//   RST       in   1          asynchronous reset, active-high
//   START     in   1          request one load/capture/unload run; sampled in IDLE only
//   PAT_IN    in   CHAIN_LEN  stimulus; after load, chain flop i holds PAT_IN[i]
//   EXP_IN    in   CHAIN_LEN  expected capture response; latched with PAT_IN
//   SO        in   1          scan-out from chain tail (flop N-1)
//   TE        out  1          scan enable to all chain flops
//   TI        out  1          scan-in to chain head (flop 0)
//   BUSY      out  1          high in any state other than IDLE
//   DONE      out  1          one-cycle pulse at end of run
//   RESP      out  CHAIN_LEN  unloaded response; RESP[i] = value captured in flop i
//   FAIL      out  1          RESP != EXP; valid from DONE until the next accepted START
// BEHAVIOUR
//   - Reset (async, RST=1): state=IDLE, TE=0, TI=0, BUSY=0, DONE=0, RESP=0,
//     FAIL=0, bit counter=0, pattern/expect regs=0.
//   - States: IDLE -> SHIFT_IN -> CAPTURE -> SHIFT_OUT -> FINISH -> IDLE.
//   - IDLE: TE=0, TI=0. START=1 at an edge latches PAT_IN/EXP_IN, clears
//     counter, clears FAIL, and enters SHIFT_IN.
//   - SHIFT_IN (N cycles): TE=1. TI=pat_reg[N-1-k] in the k-th cycle
//     (k=0..N-1), so the MSB enters first. Counter increments each edge; after
//     the edge with k=N-1, go to CAPTURE.
//   - CAPTURE (1 cycle): TE=0, TI=0. The chain loads D on this edge. Go to
//     SHIFT_OUT with counter cleared.
//   - SHIFT_OUT (N cycles): TE=1, TI=0. At the k-th edge, sample SO into
//     RESP[N-1-k]. After k=N-1, go to FINISH.
//   - FINISH (1 cycle): TE=0. DONE=1. FAIL=(RESP != exp_reg), registered
//     and held. Next state is IDLE.
//   - Latency: START accepted at edge e0 -> DONE high in the cycle after edge
//     e0+2N+1. The run takes 2N+2 cycles in total. A back-to-back START is
//     accepted at the first IDLE edge.
//   - TE and TI are Moore outputs decoded from registered state/counter/pattern
//     only; no combinational path from any input.
//   - START while BUSY=1 is ignored (not queued). PAT_IN/EXP_IN changes during
//     a run have no effect.
//   - RESP is updated only during SHIFT_OUT and holds otherwise. During
//     SHIFT_OUT it holds a partial mix of old and new bits.
//   - The counter never wraps during a run; it is cleared on entry to SHIFT_IN
//     and to SHIFT_OUT.
//   - RST asserted mid-run: immediate return to reset values, TE drops to 0
//     asynchronously, and no DONE is produced. Chain contents are then undefined.
// TESTING  (bench: N=4 chain of mux-scan flops, D = ~Q of same flop)
//   1. RST held, START pulsed -> TE=0, TI=0, BUSY=0, DONE=0, RESP=0 throughout.
//   2. PAT_IN=4'b1010, EXP_IN=4'b0101, START -> TI seq 1,0,1,0 with TE=1 for
//      4 cycles; TE=0 for 1 cycle; RESP=4'b0101; FAIL=0; DONE at cycle 10.
//   3. Same PAT_IN, EXP_IN=4'b0100 -> RESP=4'b0101, FAIL=1, DONE single cycle.
//   4. START re-pulsed during SHIFT_IN and SHIFT_OUT -> ignored, run length
//      stays 10 cycles; START the cycle after DONE -> new run starts immediately.
//   5. RST pulsed in the 2nd SHIFT_OUT cycle -> TE=0 the same cycle, BUSY=0,
//      no DONE; subsequent START with PAT_IN=4'b0011 gives RESP=4'b1100.
//   6. PAT_IN changed mid-run from 4'b1010 to 4'b1111 -> TI sequence unaffected.

Source files
------------

// File: rtl/scan_chain_ctrl_if.sv
// Sequencer/chain-side bundle for the scan chain controller.
// The sequencer side drives START/PAT_IN/EXP_IN, and the chain tail drives SO.
// The controller drives the chain controls and reports the result.
interface scan_chain_ctrl_if #(
  parameter int CHAIN_LEN = 16
);
  logic                 START;
  logic [CHAIN_LEN-1:0] PAT_IN;
  logic [CHAIN_LEN-1:0] EXP_IN;
  logic                 SO;
  logic                 TE;
  logic                 TI;
  logic                 BUSY;
  logic                 DONE;
  logic [CHAIN_LEN-1:0] RESP;
  logic                 FAIL;

  modport master (
    output START, PAT_IN, EXP_IN, SO,
    input  TE, TI, BUSY, DONE, RESP, FAIL
  );

  modport slave (
    input  START, PAT_IN, EXP_IN, SO,
    output TE, TI, BUSY, DONE, RESP, FAIL
  );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan-test initiator for one mux-scan chain.
// A run loads a pattern (MSB first) and pulses one capture cycle.
// It then unloads the response from SO and compares it against the latched expect vector.
// TE/TI are decoded from registered state only, so there is no input-to-output path.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic              CP,
  input  logic              RST,
  scan_chain_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT_IN, S_CAPTURE, S_SHIFT_OUT, S_FINISH
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     bit_idx;
  logic                 last;
  logic [CHAIN_LEN-1:0] pat_reg, exp_reg, resp, resp_nxt;
  logic                 fail;
  logic                 te, ti, busy, done;

  // Both shift phases walk the vector from the MSB down: cycle k addresses bit N-1-k.
  assign last    = (cnt == CNT_W'(CHAIN_LEN - 1));
  assign bit_idx = CNT_W'(CHAIN_LEN - 1) - cnt;

  // State register
  always_ff @(posedge CP or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and Moore decode of chain controls
  always_comb begin
    state_nxt = state;
    te        = 1'b0;
    ti        = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.START) state_nxt = S_SHIFT_IN;
      end
      S_SHIFT_IN: begin
        te = 1'b1;
        for (int i = 0; i < CHAIN_LEN; i++)
          if (bit_idx == CNT_W'(i)) ti = pat_reg[i];
        if (last) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: state_nxt = S_SHIFT_OUT;
      S_SHIFT_OUT: begin
        te = 1'b1;
        if (last) state_nxt = S_FINISH;
      end
      S_FINISH: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Response capture: each unload edge drops SO into its addressed bit
  always_comb begin
    resp_nxt = resp;
    if (state == S_SHIFT_OUT)
      for (int i = 0; i < CHAIN_LEN; i++)
        if (bit_idx == CNT_W'(i)) resp_nxt[i] = bus.SO;
  end

  // Datapath: pattern/expect latch, bit counter, response and compare result
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      cnt     <= '0;
      pat_reg <= '0;
      exp_reg <= '0;
      resp    <= '0;
      fail    <= 1'b0;
    end else begin
      resp <= resp_nxt;
      case (state)
        S_IDLE: if (bus.START) begin
          pat_reg <= bus.PAT_IN;
          exp_reg <= bus.EXP_IN;
          cnt     <= '0;
          fail    <= 1'b0;
        end
        S_SHIFT_IN:  cnt <= last ? '0 : cnt + CNT_W'(1);
        S_CAPTURE:   cnt <= '0;
        S_SHIFT_OUT: begin
          cnt <= last ? '0 : cnt + CNT_W'(1);
          // Compare against the final response so FAIL is valid in the same cycle as DONE.
          if (last) fail <= (resp_nxt != exp_reg);
        end
        default: ;
      endcase
    end
  end

  assign bus.TE   = te;
  assign bus.TI   = ti;
  assign bus.BUSY = busy;
  assign bus.DONE = done;
  assign bus.RESP = resp;
  assign bus.FAIL = fail;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: N=4 mux-scan chain whose functional D is ~Q.
// Table-driven runs and a scoreboard checked on DONE.
// Hand-written sequences cover reset hold and mid-run reset.
module tb_scan_chain_ctrl;
  localparam int N   = 4;
  localparam int CW  = 3;
  localparam int RUN = 2*N + 2;

  logic CP = 1'b0;
  logic RST;
  int   n_chk  = 0;
  int   n_pass = 0;

  scan_chain_ctrl_if #(.CHAIN_LEN(N)) bus ();
  scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(CW)) dut (.CP(CP), .RST(RST), .bus(bus.slave));

  always #5 CP = ~CP;

  // Chain model: shift TI in at flop 0 when TE=1, otherwise load D = ~Q
  logic [N-1:0] chain = '0;
  always @(posedge CP) begin
    if (bus.TE) chain <= {chain[N-2:0], bus.TI};
    else        chain <= ~chain;
  end
  assign bus.SO = chain[N-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct packed { logic [N-1:0] resp; logic fail; } sb_t;
  sb_t sb_q[$];
  sb_t sb_e;

  // Scoreboard: every DONE must match the oldest outstanding run
  always @(negedge CP) begin
    if (bus.DONE === 1'b1) begin
      if (sb_q.size() == 0) check("sb_unexpected_done", 32'd1, 32'd0);
      else begin
        sb_e = sb_q.pop_front();
        check("sb_resp", 32'(bus.RESP), 32'(sb_e.resp));
        check("sb_fail", 32'(bus.FAIL), 32'(sb_e.fail));
      end
    end
  end

  typedef struct {
    logic [N-1:0] pat, expv, resp;
    logic         fail;
    logic [RUN:1] start_mask;
    int           chg_cyc;
    logic [N-1:0] chg_pat;
  } vec_t;

  vec_t vecs[7];

  // Entered just after a negedge with the DUT idle, and returns one cycle after DONE
  task automatic run_vec(input vec_t v, input int idx);
    logic [RUN:1] te_s, ti_s, dn_s, bz_s, te_e, ti_e, dn_e;
    bus.START  = 1'b1;
    bus.PAT_IN = v.pat;
    bus.EXP_IN = v.expv;
    sb_q.push_back({v.resp, v.fail});
    for (int c = 1; c <= RUN; c++) begin
      @(negedge CP);
      bus.START = v.start_mask[c];
      if (c == v.chg_cyc) bus.PAT_IN = v.chg_pat;
      te_s[c] = bus.TE;
      ti_s[c] = bus.TI;
      dn_s[c] = bus.DONE;
      bz_s[c] = bus.BUSY;
      te_e[c] = (c <= N) || (c >= N+2 && c <= 2*N+1);
      ti_e[c] = (c <= N) ? v.pat[N-c] : 1'b0;
      dn_e[c] = (c == RUN);
      if (c == 1) check($sformatf("v%0d_fail_clr", idx), 32'(bus.FAIL), 32'd0);
    end
    check($sformatf("v%0d_te_seq", idx),   32'(te_s), 32'(te_e));
    check($sformatf("v%0d_ti_seq", idx),   32'(ti_s), 32'(ti_e));
    check($sformatf("v%0d_done_seq", idx), 32'(dn_s), 32'(dn_e));
    check($sformatf("v%0d_busy_seq", idx), 32'(bz_s), {{(32-RUN){1'b0}}, {RUN{1'b1}}});
    @(negedge CP);
    bus.START = 1'b0;
    check($sformatf("v%0d_idle", idx), {bus.BUSY, bus.DONE, bus.TE, bus.TI}, 32'd0);
    check($sformatf("v%0d_resp_hold", idx), 32'(bus.RESP), 32'(v.resp));
    check($sformatf("v%0d_fail_hold", idx), 32'(bus.FAIL), 32'(v.fail));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic dn_any;
    vecs[0] = '{pat:4'b1010, expv:4'b0101, resp:4'b0101, fail:1'b0, start_mask:'0, chg_cyc:0, chg_pat:'0};
    vecs[1] = '{pat:4'b1010, expv:4'b0100, resp:4'b0101, fail:1'b1, start_mask:'0, chg_cyc:0, chg_pat:'0};
    // START re-pulsed in SHIFT_IN (c2), SHIFT_OUT (c7) and FINISH (c10)
    vecs[2] = '{pat:4'b1010, expv:4'b0101, resp:4'b0101, fail:1'b0, start_mask:10'b1001000010, chg_cyc:0, chg_pat:'0};
    // PAT_IN changes mid-shift
    vecs[3] = '{pat:4'b1010, expv:4'b0101, resp:4'b0101, fail:1'b0, start_mask:'0, chg_cyc:2, chg_pat:4'b1111};
    vecs[4] = '{pat:4'b1000, expv:4'b0111, resp:4'b0111, fail:1'b0, start_mask:'0, chg_cyc:0, chg_pat:'0};
    vecs[5] = '{pat:4'b1111, expv:4'b0000, resp:4'b0000, fail:1'b0, start_mask:'0, chg_cyc:0, chg_pat:'0};
    vecs[6] = '{pat:4'b0110, expv:4'b0110, resp:4'b1001, fail:1'b1, start_mask:'0, chg_cyc:0, chg_pat:'0};

    // Reset held with START pulsed: everything stays quiet
    RST        = 1'b1;
    bus.START  = 1'b1;
    bus.PAT_IN = 4'b1010;
    bus.EXP_IN = 4'b0101;
    repeat (4) begin
      @(negedge CP);
      check("rst_hold", {bus.TE, bus.TI, bus.BUSY, bus.DONE, bus.RESP, bus.FAIL}, 32'd0);
    end
    bus.START = 1'b0;
    RST       = 1'b0;
    @(negedge CP);

    // Table-driven runs, issued back to back
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset during the 2nd SHIFT_OUT cycle
    bus.START  = 1'b1;
    bus.PAT_IN = 4'b1010;
    bus.EXP_IN = 4'b0101;
    @(negedge CP);
    bus.START = 1'b0;
    repeat (N + 2) @(negedge CP);
    check("mid_te_before_rst", 32'(bus.TE), 32'd1);
    #1 RST = 1'b1;
    #1;
    check("rst_te_async", {bus.TE, bus.BUSY, bus.DONE}, 32'd0);
    check("rst_resp_clr", {bus.RESP, bus.FAIL}, 32'd0);
    @(negedge CP);
    RST    = 1'b0;
    dn_any = 1'b0;
    repeat (RUN) begin
      @(negedge CP);
      dn_any |= bus.DONE;
    end
    check("no_done_after_rst", 32'(dn_any), 32'd0);

    run_vec('{pat:4'b0011, expv:4'b1100, resp:4'b1100, fail:1'b0, start_mask:'0, chg_cyc:0, chg_pat:'0}, 7);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
